// File: rtl/cp0_unit_pkg.sv
// ----------------------------------------------------------------------------
// cp0_unit_pkg
// Shared definitions for the CP0 (system control coprocessor) block:
//   - CP0 register numbers used by mfc0/mtc0 addressing
//   - exception code constants carried in Cause.ExcCode
//   - bit positions of the SR and Cause fields
//   - helpers that assemble the architectural SR/Cause words and compute
//     the exception return address
// ----------------------------------------------------------------------------
package cp0_unit_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LO   = 10;
  localparam int SR_IM_HI   = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD_BIT = 31;

  // Assemble the 32-bit SR view; unimplemented bits read as zero.
  function automatic logic [31:0] pack_sr(input logic [5:0] im,
                                          input logic       exl,
                                          input logic       ie);
    logic [31:0] v;
    v                     = '0;
    v[SR_IM_HI:SR_IM_LO]  = im;
    v[SR_EXL_BIT]         = exl;
    v[SR_IE_BIT]          = ie;
    return v;
  endfunction

  // Assemble the 32-bit Cause view; unimplemented bits read as zero.
  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] v;
    v                             = '0;
    v[CAUSE_BD_BIT]               = bd;
    v[CAUSE_IP_HI:CAUSE_IP_LO]    = ip;
    v[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc;
    return v;
  endfunction

  // Return address for an exception: a delay-slot instruction restarts at
  // its branch (PC-4, wrapping modulo 2^32). Low two bits are forced to 0
  // so eret always lands on a word boundary.
  function automatic logic [31:0] epc_target(input logic [31:0] pc,
                                             input logic        bd);
    logic [31:0] t;
    t = bd ? (pc - 32'd4) : pc;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// ----------------------------------------------------------------------------
// cp0_unit_if
// Bus between the M-stage pipeline and the CP0 block.
//   master : pipeline side, drives register addresses, mtc0 data/enable,
//            M-stage PC/BD/ExcCode, eret (EXLClr) and interrupt lines;
//            receives req, DOut and EPC_out.
//   slave  : CP0 side (cp0_unit).
// Signal names follow the established pipeline naming so the M-stage
// wrapper can connect them one-to-one.
// ----------------------------------------------------------------------------
interface cp0_unit_if;
  import cp0_unit_pkg::*;

  logic [4:0]  A_rd;       // mfc0 register number
  logic [4:0]  A_wr;       // mtc0 register number
  logic [31:0] DIn;        // mtc0 write data
  logic        writec0;    // mtc0 write enable
  logic [31:0] PC_M;       // PC of the M-stage instruction
  logic        BD_M;       // M-stage instruction is in a delay slot
  logic [4:0]  ExcCode_M;  // synchronous exception code, 0 = none
  logic        EXLClr;     // eret in M stage
  logic [5:0]  HWInt;      // level-sensitive interrupt lines
  logic        req;        // exception/interrupt taken this cycle
  logic [31:0] DOut;       // mfc0 read data
  logic [31:0] EPC_out;    // eret redirect target

  modport master (
    output A_rd, A_wr, DIn, writec0, PC_M, BD_M, ExcCode_M, EXLClr, HWInt,
    input  req, DOut, EPC_out
  );

  modport slave (
    input  A_rd, A_wr, DIn, writec0, PC_M, BD_M, ExcCode_M, EXLClr, HWInt,
    output req, DOut, EPC_out
  );

endinterface

// File: rtl/cp0_unit.sv
// ----------------------------------------------------------------------------
// cp0_unit
// CP0 register file with exception/interrupt arbitration for the M stage.
// Implements SR(12), Cause(13), EPC(14) and read-only PRId(15).
//
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : synchronous, active-low reset
//   bus   : cp0_unit_if.slave
//           inputs  A_rd, A_wr, DIn, writec0, PC_M, BD_M, ExcCode_M,
//                   EXLClr, HWInt
//           outputs req (combinational exception request / flush),
//                   DOut (mfc0 data), EPC_out (eret target)
// Parameters:
//   PRID_VALUE : contents returned for PRId
//   EPC_RESET  : EPC value after reset
// ----------------------------------------------------------------------------
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2022_0007,
  parameter logic [31:0] EPC_RESET  = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  cp0_unit_if.slave     bus
);

  // SR fields
  logic [5:0]  sr_im_q,  sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q,  sr_ie_d;
  // Cause fields
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q,  cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic        req_w;
  logic        epc_wr;

  // --------------------------------------------------------------------------
  // Exception arbitration. Gating with reset keeps the pipeline from being
  // flushed/redirected while the core is held in reset. EXL masks both
  // sources so a nested event cannot overwrite EPC.
  // --------------------------------------------------------------------------
  always_comb begin
    int_pend = reset & (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_pend = reset & (bus.ExcCode_M != EXC_INT) & ~sr_exl_q;
    req_w    = int_pend | exc_pend;
  end

  assign bus.req = req_w;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;

    // Pending-interrupt view tracks the lines every cycle, req or not.
    cause_ip_d  = bus.HWInt;

    if (req_w) begin
      // Taking an event: the mtc0 and eret of this instruction are dropped.
      sr_exl_d    = 1'b1;
      cause_bd_d  = bus.BD_M;
      cause_exc_d = int_pend ? EXC_INT : bus.ExcCode_M;
      epc_d       = epc_target(bus.PC_M, bus.BD_M);
    end else begin
      if (bus.writec0) begin
        case (bus.A_wr)
          CP0_SR: begin
            sr_im_d  = bus.DIn[SR_IM_HI:SR_IM_LO];
            sr_exl_d = bus.DIn[SR_EXL_BIT];
            sr_ie_d  = bus.DIn[SR_IE_BIT];
          end
          CP0_EPC: epc_d = bus.DIn;
          default: ;  // Cause and PRId are not software-writable
        endcase
      end
      // eret is applied after the mtc0 so it wins on the EXL bit only.
      if (bus.EXLClr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= EPC_RESET;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // --------------------------------------------------------------------------
  // mfc0 read port: current register state only, no write bypass.
  // --------------------------------------------------------------------------
  always_comb begin
    case (bus.A_rd)
      CP0_SR:    bus.DOut = pack_sr(sr_im_q, sr_exl_q, sr_ie_q);
      CP0_CAUSE: bus.DOut = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
      CP0_EPC:   bus.DOut = epc_q;
      CP0_PRID:  bus.DOut = PRID_VALUE;
      default:   bus.DOut = '0;
    endcase
  end

  // eret target: an mtc0 EPC in the same cycle is forwarded so an
  // mtc0/eret pair does not need a stall.
  assign epc_wr      = bus.writec0 & (bus.A_wr == CP0_EPC) & ~req_w;
  assign bus.EPC_out = epc_wr ? bus.DIn : epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// ----------------------------------------------------------------------------
// tb_cp0_unit
// Driver applies one input vector per clock and pushes the expected outputs
// from a register-level reference model; a monitor on the falling edge pops
// and compares req, DOut and EPC_out.
// ----------------------------------------------------------------------------
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2022_0007;
  localparam logic [31:0] EPCR = 32'h0000_3000;

  logic clk;
  logic reset;

  cp0_unit_if bus ();

  cp0_unit #(.PRID_VALUE(PRID), .EPC_RESET(EPCR)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        req;
    logic [31:0] dout;
    logic [31:0] epc_out;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_vec  = 0;
  int n_miss = 0;
  int n_txn  = 0;

  // Reference model: architectural register words.
  logic [31:0] sr_m, cause_m, epc_m;

  // --------------------------------------------------------------------------
  // Drive one cycle and predict the outputs for it, then advance the model.
  // --------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic [4:0] ard,
                       input logic [4:0] awr, input logic [31:0] din,
                       input logic wc, input logic [31:0] pc, input logic bd,
                       input logic [4:0] exc, input logic clr,
                       input logic [5:0] hw);
    exp_t        e;
    logic        ip, ep, rq;
    logic [31:0] ret;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.A_rd      = ard;
    bus.A_wr      = awr;
    bus.DIn       = din;
    bus.writec0   = wc;
    bus.PC_M      = pc;
    bus.BD_M      = bd;
    bus.ExcCode_M = exc;
    bus.EXLClr    = clr;
    bus.HWInt     = hw;

    ip = rst && ((hw & sr_m[15:10]) != 6'd0) && sr_m[0] && !sr_m[1];
    ep = rst && (exc != 5'd0) && !sr_m[1];
    rq = ip || ep;

    e.id  = n_txn;
    e.req = rq;
    case (ard)
      5'd12:   e.dout = sr_m;
      5'd13:   e.dout = cause_m;
      5'd14:   e.dout = epc_m;
      5'd15:   e.dout = PRID;
      default: e.dout = 32'd0;
    endcase
    e.epc_out = (wc && awr == 5'd14 && !rq) ? din : epc_m;
    exp_q.push_back(e);
    n_txn++;

    if (!rst) begin
      sr_m    = 32'd0;
      cause_m = 32'd0;
      epc_m   = EPCR;
    end else begin
      cause_m = (cause_m & ~32'h0000_FC00) | (32'(hw) * 32'd1024);
      if (rq) begin
        sr_m    = sr_m | 32'd2;
        cause_m = (cause_m & 32'h0000_FC00) | (bd ? 32'h8000_0000 : 32'd0)
                  | (ip ? 32'd0 : 32'(exc) * 32'd4);
        ret     = bd ? pc - 32'd4 : pc;
        epc_m   = ret & 32'hFFFF_FFFC;
      end else begin
        if (wc && awr == 5'd12) sr_m  = din & 32'h0000_FC03;
        if (wc && awr == 5'd14) epc_m = din;
        if (clr) sr_m = sr_m & ~32'd2;
      end
    end
  endtask

  // Idle cycle that only reads a register.
  task automatic rd(input logic [4:0] ard, input logic [5:0] hw);
    drive(1'b1, ard, 5'd0, 32'd0, 1'b0, 32'h0000_3000, 1'b0, 5'd0, 1'b0, hw);
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      $display("txn %0d: req=%0b dout=%08h epc_out=%08h", mon_e.id,
               bus.req, bus.DOut, bus.EPC_out);
      n_vec++;
      if (bus.req !== mon_e.req) begin
        n_miss++;
        $display("FAIL req txn %0d: got %0b expected %0b", mon_e.id,
                 bus.req, mon_e.req);
      end
      n_vec++;
      if (bus.DOut !== mon_e.dout) begin
        n_miss++;
        $display("FAIL dout txn %0d: got %08h expected %08h", mon_e.id,
                 bus.DOut, mon_e.dout);
      end
      n_vec++;
      if (bus.EPC_out !== mon_e.epc_out) begin
        n_miss++;
        $display("FAIL epc_out txn %0d: got %08h expected %08h", mon_e.id,
                 bus.EPC_out, mon_e.epc_out);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [4:0] exc_tab [0:6];

  initial begin
    exc_tab[0] = 5'd0; exc_tab[1] = 5'd0; exc_tab[2] = 5'd0;
    exc_tab[3] = 5'd4; exc_tab[4] = 5'd5; exc_tab[5] = 5'd10;
    exc_tab[6] = 5'd12;

    reset = 1'b0;
    bus.A_rd = 5'd0; bus.A_wr = 5'd0; bus.DIn = 32'd0; bus.writec0 = 1'b0;
    bus.PC_M = 32'd0; bus.BD_M = 1'b0; bus.ExcCode_M = 5'd0;
    bus.EXLClr = 1'b0; bus.HWInt = 6'd0;
    // One unchecked reset edge so the DUT leaves its unknown power-up state.
    @(posedge clk);
    sr_m = 32'd0; cause_m = 32'd0; epc_m = EPCR;

    // Reset held for two cycles; req must stay low despite pending events.
    drive(1'b0, 5'd12, 5'd0, 32'd0, 1'b0, 32'h100, 1'b0, 5'd12, 1'b0, 6'h3F);
    drive(1'b0, 5'd13, 5'd0, 32'd0, 1'b0, 32'h100, 1'b0, 5'd4, 1'b0, 6'h3F);
    rd(5'd14, 6'd0);
    rd(5'd13, 6'd0);

    // Enable IM/IE, then raise HWInt[2].
    drive(1'b1, 5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0);
    drive(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0000_3040, 1'b0, 5'd0, 1'b0, 6'b000100);
    rd(5'd13, 6'b000100);
    rd(5'd12, 6'b000100);
    rd(5'd14, 6'd0);

    // eret, clear SR, then an overflow in a delay slot.
    drive(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 6'd0);
    drive(1'b1, 5'd12, 5'd12, 32'd0, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0);
    drive(1'b1, 5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_3010, 1'b1, 5'd12, 1'b0, 6'd0);
    rd(5'd13, 6'd0);
    rd(5'd14, 6'd0);

    // Second exception while EXL=1 is ignored; then eret.
    drive(1'b1, 5'd14, 5'd0, 32'd0, 1'b0, 32'h0000_5000, 1'b0, 5'd4, 1'b0, 6'd0);
    drive(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 6'd0);
    rd(5'd12, 6'd0);

    // Interrupt and RI together: interrupt wins.
    drive(1'b1, 5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0);
    drive(1'b1, 5'd13, 5'd0, 32'd0, 1'b0, 32'h0000_3100, 1'b0, 5'd10, 1'b0, 6'b000001);
    rd(5'd13, 6'd0);

    // mtc0 EPC forwarding, then mtc0 suppressed by a req.
    drive(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 6'd0);
    drive(1'b1, 5'd14, 5'd14, 32'h0000_4000, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0, 6'd0);
    drive(1'b1, 5'd14, 5'd14, 32'h0000_5000, 1'b1, 32'h0000_3200, 1'b0, 5'd5, 1'b0, 6'd0);
    rd(5'd14, 6'd0);

    // PC-4 wraps from 0; eret together with mtc0 SR that sets EXL.
    drive(1'b1, 5'd12, 5'd0, 32'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 6'd0);
    drive(1'b1, 5'd14, 5'd0, 32'd0, 1'b0, 32'h0, 1'b1, 5'd4, 1'b0, 6'd0);
    rd(5'd14, 6'd0);
    drive(1'b1, 5'd12, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 5'd0, 1'b1, 6'd0);
    rd(5'd12, 6'd0);
    rd(5'd15, 6'd0);
    rd(5'd3, 6'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0]  ard, awr;
      logic [31:0] din;
      ard = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      awr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      din = $urandom;
      if ($urandom_range(0, 1) == 1) din[0] = 1'b1;
      drive(($urandom_range(0, 40) != 0), ard, awr, din,
            ($urandom_range(0, 2) == 0), $urandom, 1'($urandom),
            exc_tab[$urandom_range(0, 6)], ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0);
    end

    @(posedge clk);
    @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter PRID_VALUE, default 32'h2022_0007, read-only PRId contents.
REQ-002 Parameter EPC_RESET, default 32'h0000_3000, EPC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk; reset asserted when 0.
REQ-005 A_rd  input  5  CP0 register number for mfc0 read.
REQ-006 A_wr  input  5  CP0 register number for mtc0 write.
REQ-007 DIn  input  32  mtc0 write data (RD2_M).
REQ-008 writec0  input  1  mtc0 write enable (writec0_M).
REQ-009 PC_M  input  32  PC of the instruction in M stage.
REQ-010 BD_M  input  1  M-stage instruction sits in a branch delay slot.
REQ-011 ExcCode_M  input  5  synchronous exception code from upstream; 0 = none.
REQ-012 EXLClr  input  1  eret in M stage; clears SR.EXL.
REQ-013 HWInt  input  6  external interrupt lines, level-sensitive.
REQ-014 req  output  1  exception/interrupt taken this cycle; drives pipeline-register flush and PC redirect.
REQ-015 DOut  output  32  mfc0 read data.
REQ-016 EPC_out  output  32  current EPC for eret redirect.

Function
REQ-017 SR (12) fields: IM[15:10], EXL[1], IE[0]; all other bits read 0, writes ignored.
REQ-018 Cause (13) fields: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0; Cause is not writable by mtc0.
REQ-019 EPC (14): full 32-bit register, writable by mtc0; PRId (15) returns PRID_VALUE; any other address reads 0.
REQ-020 int_pend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL; exc_pend = (ExcCode_M != 0) & ~SR.EXL.
REQ-021 req = int_pend | exc_pend, combinational, same cycle; interrupt has priority over a synchronous exception.
REQ-022 Cause.IP <= HWInt every cycle, including req cycles.
REQ-023 On req: SR.EXL <= 1; Cause.BD <= BD_M; Cause.ExcCode <= 0 if int_pend, else ExcCode_M; EPC <= (BD_M ? PC_M-4 : PC_M) with bits [1:0] forced to 0.
REQ-024 When req=0 and writec0=1, register A_wr takes DIn on the next edge, masked per REQ-017 to REQ-019; when req=1, the mtc0 write is suppressed.
REQ-025 When EXLClr=1 and req=0, SR.EXL <= 0; when EXLClr and req are both 1, req wins and EXL stays 1.
REQ-026 When mtc0 to SR and EXLClr occur in the same cycle, EXLClr overrides the EXL bit and the remaining fields take DIn.
REQ-027 DOut is combinational from current register state; there is no write-to-read bypass.
REQ-028 EPC_out = DIn when writec0=1 and A_wr=14 and req=0; otherwise EPC_out = EPC register.
REQ-029 PC_M-4 wraps modulo 2^32 with no error.

Reset
REQ-030 While reset=0 at a clock edge: SR <= 0, Cause <= 0, EPC <= EPC_RESET.
REQ-031 req is forced to 0 combinationally while reset=0.
REQ-032 Reset asserted during a req cycle discards the exception; reset values apply.

Structure
REQ-033 A shared package holds:
- CP0 register numbers: SR 12, Cause 13, EPC 14, PRId 15.
- ExcCode constants: Int 0, AdEL 4, AdES 5, RI 10, Ov 12.
- Field bit-position constants for SR and Cause.
REQ-034 The block is a single module with no sub-modules; the M-stage wrapper instantiates it, and req feeds the req input of every pipeline register.

Verification
REQ-035 Reset with reset=0 for 2 cycles -> DOut reads 0 for SR and Cause and 0x3000 for EPC; req=0.
REQ-036 mtc0 SR with DIn=0x0000_FC01, then HWInt=6'b000100 -> req=1 the same cycle; next cycle Cause=0x0000_1000, SR.EXL=1, EPC=PC_M.
REQ-037 ExcCode_M=12, BD_M=1, PC_M=0x3010, SR=0 -> req=1; then Cause.BD=1, ExcCode=12, EPC=0x300C.
REQ-038 EXL=1 and a second ExcCode_M=4 -> req=0; EPC unchanged; then EXLClr=1 -> next cycle SR.EXL=0.
REQ-039 Interrupt and ExcCode_M=10 in the same cycle -> Cause.ExcCode=0 (interrupt priority).
REQ-040 mtc0 EPC with DIn=0x4000 -> EPC_out=0x4000 the same cycle; mtc0 during a req cycle -> write suppressed.
